// File: rtl/uart_tx_fifo_if.sv
// Valid/ready word handshake between a word source and the UART transmitter FIFO.
interface uart_tx_fifo_if #(
    parameter int DATA_WIDTH_P = 8
);
    logic [DATA_WIDTH_P-1:0] data_i;
    logic                    t_valid_i;
    logic                    t_ready_o;

    modport master (output data_i, output t_valid_i, input t_ready_o);
    modport slave  (input data_i, input t_valid_i, output t_ready_o);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO: start bit, LSB-first data, optional parity,
// 1 or 2 stop bits, bit period latched per frame from prescale_i.
module uart_tx_fifo #(
    parameter int DATA_WIDTH_P = 8,
    parameter int DEPTH_P      = 4,
    parameter int PARITY_P     = 0,
    parameter int STOP_BITS_P  = 1,
    parameter int PRESCALE_W_P = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    uart_tx_fifo_if.slave                t_if,
    input  logic [PRESCALE_W_P-1:0]      prescale_i,
    output logic                         tx_o,
    output logic                         busy_o,
    output logic [$clog2(DEPTH_P+1)-1:0] fifo_count_o
);
    localparam int PTR_W = $clog2(DEPTH_P);
    localparam int CNT_W = $clog2(DEPTH_P + 1);
    localparam int BIT_W = 4;
    localparam logic [CNT_W-1:0] FULL_C      = CNT_W'(DEPTH_P);
    localparam logic [BIT_W-1:0] LAST_DATA_C = BIT_W'(DATA_WIDTH_P - 1);
    localparam logic [BIT_W-1:0] LAST_STOP_C = BIT_W'(STOP_BITS_P - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic parity_bit(input logic [DATA_WIDTH_P-1:0] word);
        logic p;
        p = ^word;
        return (PARITY_P == 2) ? ~p : p;
    endfunction

    logic [DATA_WIDTH_P-1:0] mem_r [DEPTH_P];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        count_r;
    logic                    ready_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    empty_s;
    logic [DATA_WIDTH_P-1:0] head_s;
    logic [PRESCALE_W_P-1:0] p_in_s;

    state_t                  state_r, state_nxt_s;
    logic [PRESCALE_W_P-1:0] cnt_r, cnt_nxt_s;
    logic [PRESCALE_W_P-1:0] p_r, p_nxt_s;
    logic [BIT_W-1:0]        bit_cnt_r, bit_cnt_nxt_s;
    logic [DATA_WIDTH_P-1:0] shift_r, shift_nxt_s;
    logic                    par_r, par_nxt_s;
    logic                    tx_r, tx_nxt_s;
    logic                    busy_r, busy_nxt_s;
    logic                    baud_done_s;
    logic                    load_s;

    assign ready_s        = (count_r != FULL_C);
    assign t_if.t_ready_o = ready_s;
    assign push_s         = t_if.t_valid_i && ready_s;
    assign empty_s        = (count_r == {CNT_W{1'b0}});
    assign head_s         = mem_r[rd_ptr_r];
    assign p_in_s         = (prescale_i == {PRESCALE_W_P{1'b0}}) ?
                            {{(PRESCALE_W_P-1){1'b0}}, 1'b1} : prescale_i;
    assign baud_done_s    = (cnt_r == p_r - {{(PRESCALE_W_P-1){1'b0}}, 1'b1});
    assign pop_s          = load_s;

    assign tx_o         = tx_r;
    assign busy_o       = busy_r;
    assign fifo_count_o = count_r;

    // FIFO storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= t_if.data_i;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame sequencer next state; tx and busy are computed one edge ahead so they leave registered.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        p_nxt_s       = p_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        par_nxt_s     = par_r;
        tx_nxt_s      = tx_r;
        busy_nxt_s    = busy_r;
        load_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                tx_nxt_s   = 1'b1;
                busy_nxt_s = 1'b0;
                load_s     = !empty_s;
            end
            ST_START: begin
                if (baud_done_s) begin
                    cnt_nxt_s     = {PRESCALE_W_P{1'b0}};
                    bit_cnt_nxt_s = {BIT_W{1'b0}};
                    tx_nxt_s      = shift_r[0];
                    shift_nxt_s   = {1'b0, shift_r[DATA_WIDTH_P-1:1]};
                    state_nxt_s   = ST_DATA;
                end else begin
                    cnt_nxt_s = cnt_r + PRESCALE_W_P'(1'b1);
                end
            end
            ST_DATA: begin
                if (baud_done_s) begin
                    cnt_nxt_s = {PRESCALE_W_P{1'b0}};
                    if (bit_cnt_r == LAST_DATA_C) begin
                        bit_cnt_nxt_s = {BIT_W{1'b0}};
                        if (PARITY_P != 0) begin
                            tx_nxt_s    = par_r;
                            state_nxt_s = ST_PARITY;
                        end else begin
                            tx_nxt_s    = 1'b1;
                            state_nxt_s = ST_STOP;
                        end
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1'b1);
                        tx_nxt_s      = shift_r[0];
                        shift_nxt_s   = {1'b0, shift_r[DATA_WIDTH_P-1:1]};
                    end
                end else begin
                    cnt_nxt_s = cnt_r + PRESCALE_W_P'(1'b1);
                end
            end
            ST_PARITY: begin
                if (baud_done_s) begin
                    cnt_nxt_s     = {PRESCALE_W_P{1'b0}};
                    bit_cnt_nxt_s = {BIT_W{1'b0}};
                    tx_nxt_s      = 1'b1;
                    state_nxt_s   = ST_STOP;
                end else begin
                    cnt_nxt_s = cnt_r + PRESCALE_W_P'(1'b1);
                end
            end
            ST_STOP: begin
                if (baud_done_s) begin
                    cnt_nxt_s = {PRESCALE_W_P{1'b0}};
                    if (bit_cnt_r == LAST_STOP_C) begin
                        // A queued word chains straight into its start bit with no idle gap.
                        load_s      = !empty_s;
                        tx_nxt_s    = 1'b1;
                        busy_nxt_s  = 1'b0;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1'b1);
                    end
                end else begin
                    cnt_nxt_s = cnt_r + PRESCALE_W_P'(1'b1);
                end
            end
            default: begin
                tx_nxt_s    = 1'b1;
                busy_nxt_s  = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (load_s) begin
            shift_nxt_s = head_s;
            par_nxt_s   = parity_bit(head_s);
            p_nxt_s     = p_in_s;
            cnt_nxt_s   = {PRESCALE_W_P{1'b0}};
            tx_nxt_s    = 1'b0;
            busy_nxt_s  = 1'b1;
            state_nxt_s = ST_START;
        end else begin
            p_nxt_s = p_r;
        end
    end

    // Frame sequencer state register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {PRESCALE_W_P{1'b0}};
            p_r       <= {{(PRESCALE_W_P-1){1'b0}}, 1'b1};
            bit_cnt_r <= {BIT_W{1'b0}};
            shift_r   <= {DATA_WIDTH_P{1'b0}};
            par_r     <= 1'b0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            p_r       <= p_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            par_r     <= par_nxt_s;
            tx_r      <= tx_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Drives three transmitter variants (even parity, odd parity, no parity + 2 stop bits)
// with shared stimulus and compares every cycle against a frame-level model.
module tb_uart_tx_fifo;
    localparam int N  = 3;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] prescale = 16'd4;
    logic [W-1:0]  din    [N];
    logic          vld    [N];
    logic          tx_w   [N];
    logic          busy_w [N];
    logic          rdy_w  [N];
    logic [CW-1:0] cnt_w  [N];

    int total = 0;
    int bad   = 0;

    // model: FIFO contents and the per-cycle line levels of the frame in flight
    logic [W-1:0] mq [N][D];
    int           mq_n [N];
    logic         ml [N][256];
    int           ml_pos [N];
    int           ml_len [N];
    // sources
    logic [W-1:0] src_w [N][64];
    int           src_n [N];
    int           src_idx [N];
    bit           hold [N];
    bit           took [N];
    int           rate;
    int           run [N];
    int           last_run [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int PAR_L  = (g == 0) ? 1 : ((g == 1) ? 2 : 0);
        localparam int STOP_L = (g == 2) ? 2 : 1;
        uart_tx_fifo_if #(.DATA_WIDTH_P(W)) bus ();
        assign bus.data_i    = din[g];
        assign bus.t_valid_i = vld[g];
        assign rdy_w[g]      = bus.t_ready_o;
        uart_tx_fifo #(
            .DATA_WIDTH_P(W), .DEPTH_P(D), .PARITY_P(PAR_L),
            .STOP_BITS_P(STOP_L), .PRESCALE_W_P(PW)
        ) dut (
            .clk(clk), .rst(rst), .t_if(bus.slave), .prescale_i(prescale),
            .tx_o(tx_w[g]), .busy_o(busy_w[g]), .fifo_count_o(cnt_w[g])
        );
    end

    function automatic int par_of(int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 0);
    endfunction
    function automatic int stop_of(int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic int eff_p(int p);
        return (p < 1) ? 1 : p;
    endfunction
    function automatic int frame_len(int i, int p);
        return (1 + W + ((par_of(i) != 0) ? 1 : 0) + stop_of(i)) * eff_p(p);
    endfunction

    task automatic chk(string tag, int inst, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t: got %0h expected %0h", tag, inst, $time, got, exp);
        end
    endtask

    task automatic put_bits(int i, logic b, int n);
        for (int k = 0; k < n; k++) begin
            ml[i][ml_len[i]] = b;
            ml_len[i]++;
        end
    endtask

    task automatic build_frame(int i, logic [W-1:0] w, int p);
        int q;
        q = eff_p(p);
        ml_len[i] = 0;
        ml_pos[i] = 0;
        put_bits(i, 1'b0, q);
        for (int b = 0; b < W; b++) put_bits(i, w[b], q);
        if (par_of(i) != 0) put_bits(i, (^w) ^ (par_of(i) == 2), q);
        put_bits(i, 1'b1, stop_of(i) * q);
    endtask

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            if (!hold[i] && src_idx[i] < src_n[i] && $urandom_range(99, 0) < rate) hold[i] = 1'b1;
            vld[i] = hold[i];
            din[i] = hold[i] ? src_w[i][src_idx[i]] : W'($urandom);
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_n[i] = 0; src_idx[i] = 0; hold[i] = 1'b0;
        end
    endtask

    task automatic add_word(logic [W-1:0] w);
        for (int i = 0; i < N; i++) begin
            src_w[i][src_n[i]] = w;
            src_n[i]++;
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += (src_n[i] - src_idx[i]) + mq_n[i] + (ml_len[i] - ml_pos[i]);
        return s;
    endfunction

    // one clock: check outputs, advance the model at the edge, then refresh the sources
    task automatic tick();
        int rem;
        bit acc;
        for (int i = 0; i < N; i++) begin
            rem = ml_len[i] - ml_pos[i];
            chk("tx", i, tx_w[i], (rem > 0) ? ml[i][ml_pos[i]] : 1'b1);
            chk("busy", i, busy_w[i], rem > 0);
            chk("count", i, cnt_w[i], mq_n[i]);
            chk("ready", i, rdy_w[i], mq_n[i] != D);
            if (busy_w[i] === 1'b1) begin
                run[i]++;
            end else begin
                if (run[i] != 0) last_run[i] = run[i];
                run[i] = 0;
            end
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            took[i] = 1'b0;
            if (rst) begin
                mq_n[i] = 0; ml_len[i] = 0; ml_pos[i] = 0;
            end else begin
                acc = vld[i] && (mq_n[i] != D);
                rem = ml_len[i] - ml_pos[i];
                if (rem <= 1 && mq_n[i] > 0) begin
                    build_frame(i, mq[i][0], int'(prescale));
                    for (int k = 0; k < D - 1; k++) mq[i][k] = mq[i][k+1];
                    mq_n[i]--;
                end else if (rem > 0) begin
                    ml_pos[i]++;
                end
                if (acc) begin
                    mq[i][mq_n[i]] = din[i];
                    mq_n[i]++;
                    took[i] = 1'b1;
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (took[i]) begin
                hold[i] = 1'b0;
                src_idx[i]++;
            end
        end
        drive_src();
    endtask

    task automatic drain(int budget, bit wiggle);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            tick();
            n++;
            if (wiggle && $urandom_range(99, 0) < 2) prescale = PW'($urandom_range(6, 0));
        end
        chk("drain_left", 0, pending(), 0);
        tick();
    endtask

    task automatic run_single(logic [W-1:0] w, int p);
        prescale = PW'(p);
        clear_src();
        add_word(w);
        drive_src();
        drain(500, 1'b0);
        for (int i = 0; i < N; i++) chk("frame_len", i, last_run[i], frame_len(i, p));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b0; din[i] = '0; hold[i] = 1'b0; src_n[i] = 0; src_idx[i] = 0;
            mq_n[i] = 0; ml_len[i] = 0; ml_pos[i] = 0; run[i] = 0; last_run[i] = 0;
        end
        rate = 100;
        repeat (5) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("rst_tx", i, tx_w[i], 1'b1);
            chk("rst_busy", i, busy_w[i], 1'b0);
            chk("rst_count", i, cnt_w[i], 0);
            chk("rst_ready", i, rdy_w[i], 1'b1);
        end
        rst = 1'b0;

        run_single(8'h55, 4);
        run_single(8'h03, 2);
        run_single(8'hA0, 1);
        run_single(8'h3C, 0);

        // back-pressure: six words at 8 cycles/bit
        prescale = 16'd8;
        clear_src();
        for (int w = 1; w <= 6; w++) add_word(W'(w));
        drive_src();
        repeat (5) tick();
        for (int i = 0; i < N; i++) begin
            chk("bp_count", i, cnt_w[i], 4);
            chk("bp_ready", i, rdy_w[i], 1'b0);
        end
        drain(2000, 1'b0);
        for (int i = 0; i < N; i++) chk("bp_busy_run", i, last_run[i], 6 * frame_len(i, 8));

        // abort mid-data with two words queued
        prescale = 16'd4;
        clear_src();
        add_word(8'h5A); add_word(8'h11); add_word(8'h22);
        drive_src();
        repeat (14) tick();
        for (int i = 0; i < N; i++) chk("abort_queued", i, cnt_w[i], 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_src();
        for (int i = 0; i < N; i++) begin
            chk("abort_tx", i, tx_w[i], 1'b1);
            chk("abort_count", i, cnt_w[i], 0);
            chk("abort_busy", i, busy_w[i], 1'b0);
        end
        prescale = 16'd3;
        add_word(8'h0F);
        drive_src();
        repeat (6) tick();
        prescale = 16'd7;
        drain(500, 1'b0);
        for (int i = 0; i < N; i++) chk("latched_p", i, last_run[i], frame_len(i, 3));

        // randomized traffic, gaps and prescale changes
        for (int r = 0; r < 4; r++) begin
            clear_src();
            rate = $urandom_range(100, 20);
            prescale = PW'($urandom_range(6, 0));
            for (int k = 0; k < 20; k++) add_word(W'($urandom));
            drive_src();
            drain(5000, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
